// File: rtl/count_seg_display.sv
// Display stage for the counter FSM: sequential double-dabble of the 8-bit count
// into three BCD digits, plus a time-multiplexed 3-digit 7-segment driver.
module count_seg_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  count_in,
    input  logic        skip_flag,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        bcd_valid
);
    localparam int             CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_POL  = {7{COMMON_ANODE}};
    localparam logic [2:0]     AN_POL   = {3{COMMON_ANODE}};
    localparam logic [6:0]     SEG_ZERO = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion engine
    // ------------------------------------------------------------------
    state_t      r_state, w_state_next;
    logic [19:0] r_shift, w_shift_next;
    logic [2:0]  r_iter,  w_iter_next;
    logic [7:0]  r_capt,  w_capt_next;
    logic [7:0]  r_last,  w_last_next;
    logic        r_force, w_force_next;
    logic [11:0] r_bcd,   w_bcd_next;
    logic        r_valid, w_valid_next;

    logic [19:0] w_adj;
    logic [19:0] w_shifted;

    // Add-3 correction on each BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            localparam int LSB = 8 + 4 * gi;
            assign w_adj[LSB +: 4] = (r_shift[LSB +: 4] >= 4'd5) ?
                                     (r_shift[LSB +: 4] + 4'd3) : r_shift[LSB +: 4];
        end
    endgenerate
    assign w_adj[7:0] = r_shift[7:0];
    assign w_shifted  = w_adj << 1;

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_iter_next  = r_iter;
        w_capt_next  = r_capt;
        w_last_next  = r_last;
        w_force_next = r_force;
        w_bcd_next   = r_bcd;
        w_valid_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((count_in != r_last) || r_force) begin
                    w_shift_next = {12'd0, count_in};
                    w_capt_next  = count_in;
                    w_force_next = 1'b0;
                    w_iter_next  = 3'd0;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift_next = w_shifted;
                w_iter_next  = r_iter + 3'd1;
                if (r_iter == 3'd7) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_bcd_next   = r_shift[19:8];
                w_last_next  = r_capt;
                w_valid_next = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= 20'd0;
            r_iter  <= 3'd0;
            r_capt  <= 8'd0;
            r_last  <= 8'd0;
            r_force <= 1'b1;
            r_bcd   <= 12'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_iter  <= w_iter_next;
            r_capt  <= w_capt_next;
            r_last  <= w_last_next;
            r_force <= w_force_next;
            r_bcd   <= w_bcd_next;
            r_valid <= w_valid_next;
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_digit;
    logic          r_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_digit   <= (r_digit == 2'd2) ? 2'd0 : (r_digit + 2'd1);
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    logic [3:0] w_nibble;
    logic       w_blank;
    logic [2:0] w_an_ah;
    logic [6:0] w_seg_ah;
    logic       w_dp_ah;

    // Leading-zero blanking looks at the latched result, never the shifter.
    always_comb begin
        w_nibble = r_bcd[3:0];
        w_blank  = 1'b0;
        w_an_ah  = 3'b001;
        case (r_digit)
            2'd1: begin
                w_nibble = r_bcd[7:4];
                w_blank  = (r_bcd[11:4] == 8'd0);
                w_an_ah  = 3'b010;
            end
            2'd2: begin
                w_nibble = r_bcd[11:8];
                w_blank  = (r_bcd[11:8] == 4'd0);
                w_an_ah  = 3'b100;
            end
            default: begin
                w_nibble = r_bcd[3:0];
                w_blank  = 1'b0;
                w_an_ah  = 3'b001;
            end
        endcase
        w_seg_ah = w_blank ? 7'b0000000 : seg_decode(w_nibble);
        w_dp_ah  = (r_digit == 2'd0) && r_skip;
    end

    logic [6:0] r_seg;
    logic [2:0] r_an;
    logic       r_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip <= 1'b0;
            r_seg  <= SEG_ZERO ^ SEG_POL;
            r_an   <= 3'b001 ^ AN_POL;
            r_dp   <= COMMON_ANODE;
        end else begin
            r_skip <= skip_flag;
            r_seg  <= w_seg_ah ^ SEG_POL;
            r_an   <= w_an_ah ^ AN_POL;
            r_dp   <= w_dp_ah ^ COMMON_ANODE;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule

// File: tb/tb_count_seg_display.sv
// Randomised scoreboard bench for count_seg_display: conversion results and timing,
// scan order/hold, blanking, decimal point and reset behaviour.
module tb_count_seg_display;
    localparam int RD = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [7:0]  count_in  = 8'd0;
    logic        skip_flag = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  an;
    logic [11:0] bcd;
    logic        bcd_valid;

    always #5 clk = ~clk;

    count_seg_display #(
        .REFRESH_DIV (RD),
        .COMMON_ANODE(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .skip_flag(skip_flag),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .bcd      (bcd),
        .bcd_valid(bcd_valid)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic rst_s    = 1'b1;
    logic sk1      = 1'b0;
    logic sk2      = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
        sk1   <= skip_flag;
        sk2   <= sk1;
    end

    typedef struct {
        logic [11:0] bcd;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    int          next_free = 0;
    int          last_cap  = 0;
    int          last_conv = -1;
    int          n_txn     = 0;
    logic [11:0] model_bcd = 12'd0;
    logic [11:0] prev_bcd  = 12'd0;
    int          model_cyc = 0;
    logic [6:0]  seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] next_an(input logic [2:0] a);
        case (a)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    task automatic push_conv(input int v, input int e);
        exp_t x;
        x.bcd = to_bcd(v);
        x.at  = e + 9;
        exp_q.push_back(x);
        next_free = e + 10;
        last_cap  = e;
        last_conv = v;
    endtask

    // A new value is captured on the next edge if idle, else when the engine frees up.
    task automatic set_count(input int v);
        int e;
        while (cyc < last_cap) @(negedge clk);
        count_in = 8'(v);
        e = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        if (v != last_conv) push_conv(v, e);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < next_free) @(negedge clk);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        push_conv(int'(count_in), cyc + 1);
    endtask

    // Monitor: display checks first, then scoreboard pops.
    int          rst_age = 0;
    int          run_len = 0;
    bit          run_ok  = 1'b0;
    logic [2:0]  last_an = 3'b110;
    logic [11:0] shown;
    int          d;
    logic [3:0]  nib;
    logic [6:0]  exp_seg;
    bit          blank;
    exp_t        got;

    always @(negedge clk) begin
        if (rst_s) begin
            model_bcd = 12'd0;
            prev_bcd  = 12'd0;
            model_cyc = cyc;
            rst_age   = 0;
            run_ok    = 1'b0;
            run_len   = 0;
            last_an   = an;
        end else begin
            rst_age++;
            if (rst_age >= 3) begin
                shown = (cyc > model_cyc) ? model_bcd : prev_bcd;
                d = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : -1;
                n_checks++;
                if (d < 0) begin
                    n_fail++;
                    $display("FAIL an_onehot: got %b expected one low bit at cycle %0d", an, cyc);
                end else begin
                    nib   = shown[4*d +: 4];
                    blank = (d == 2 && shown[11:8] == 4'd0) || (d == 1 && shown[11:4] == 8'd0);
                    exp_seg = blank ? 7'h7F : ~seg_tab[nib];
                    check("seg", 32'(seg), 32'(exp_seg));
                    check("dp", 32'(dp), (d == 0 && sk2) ? 32'd0 : 32'd1);
                end
                if (an != last_an) begin
                    if (run_ok) begin
                        check("an_hold", run_len, RD);
                        check("an_order", 32'(an), 32'(next_an(last_an)));
                    end
                    run_ok  = 1'b1;
                    run_len = 1;
                    last_an = an;
                end else begin
                    run_len++;
                end
            end
            if (bcd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got bcd=0x%03h with none expected at cycle %0d", bcd, cyc);
                end else begin
                    got = exp_q.pop_front();
                    n_txn++;
                    $display("txn %0d: bcd=0x%03h expected 0x%03h cycle %0d expected %0d",
                             n_txn, bcd, got.bcd, cyc, got.at);
                    check("bcd", 32'(bcd), 32'(got.bcd));
                    check("latency", cyc, got.at);
                    prev_bcd  = model_bcd;
                    model_bcd = got.bcd;
                    model_cyc = cyc;
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                got = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_valid: no pulse, required bcd=0x%03h at cycle %0d", got.bcd, got.at);
            end
        end
    end

    initial begin
        int v;
        int e;
        int guard;
        int directed [6] = '{255, 0, 9, 10, 99, 100};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'(3'b110));
        check("rst_seg", 32'(seg), 32'(7'b1000000));
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        release_rst();

        // Directed boundary conversions
        foreach (directed[i]) begin
            wait_idle();
            set_count(directed[i]);
        end

        // Change during conversion
        wait_idle();
        set_count(10);
        repeat (3) @(negedge clk);
        set_count(99);

        // Scan, blanking and decimal point
        wait_idle();
        set_count(5);
        skip_flag = 1'b0;
        repeat (30) @(negedge clk);
        skip_flag = 1'b1;
        repeat (30) @(negedge clk);
        skip_flag = 1'b0;
        repeat (10) @(negedge clk);

        // Random values and gaps
        repeat (40) begin
            v = $urandom_range(0, 255);
            set_count(v);
            if ($urandom_range(0, 3) == 0) skip_flag = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end

        // Reset in the middle of a conversion
        wait_idle();
        if (last_conv == 200) begin
            set_count(7);
            wait_idle();
        end
        set_count(200);
        e = last_cap;
        while (cyc < e + 3) @(negedge clk);
        rst = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at > cyc) exp_q.delete(i);
        end
        repeat (2) @(negedge clk);
        check("midrst_bcd", 32'(bcd), 32'h000);
        check("midrst_valid", 32'(bcd_valid), 32'd0);
        release_rst();

        // Drain outstanding expectations
        guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected pulses outstanding, required 0", exp_q.size());
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seg_display.md
# count_seg_display

Downstream display stage for the FSM counter: consumes the 8-bit `count_out` and the `skip_to_five` flag, converts the count to three BCD digits with a sequential double-dabble engine, and drives a time-multiplexed 3-digit 7-segment display. It also exposes the latched BCD value with a one-cycle valid strobe, so other logic can log or compare counts.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled. Must be ≥ 2.
- `COMMON_ANODE`, 1: when 1, `seg`, `dp` and `an` are active-low. When 0, they are active-high.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `count_in`  in  8  count from the counter FSM (`count_out`).
- `skip_flag`  in  1  `skip_to_five` from the counter FSM.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, with `seg[0]` = a.
- `dp`  out  1  decimal point.
- `an`  out  3  one-hot digit enable. `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds.
- `bcd`  out  12  latched result {hundreds, tens, ones}, one nibble each.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.

## Operation
- **Conversion FSM** has three states:
  - IDLE: if `count_in` ≠ last converted value, or the post-reset force flag is set, capture `count_in` into a 20-bit shift register {12'b0, count}, clear the force flag and go to SHIFT.
  - SHIFT: eight iterations. Each iteration first adds 3 to any BCD nibble ≥ 5, then shifts the whole register left by 1. A 3-bit iteration counter runs 0..7, and the FSM goes to DONE after iteration 7.
  - DONE: `bcd` ← upper 12 bits, last-converted ← captured value, `bcd_valid` ← 1, then go to IDLE.
- `count_in` changes during SHIFT or DONE are ignored. They are picked up by the IDLE comparison afterwards, so the final value is always converted.
- Output range is 0x000–0x255. Nibbles never exceed 9.
- **Scan:**
  - The refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - The display scans the latched `bcd`, never the in-flight shift register.
- **Leading-zero blanking:**
  - Hundreds is blank when it is 0.
  - Tens is blank when both hundreds and tens are 0.
  - Ones is always shown.
  - A blank digit has all segments off, but `an` is still driven for it.
- **Decoding:**
  - Standard hex-free decode for 0–9. Active-high patterns: 0=0111111, 1=0000110, 5=1101101, 9=1101111.
  - `dp` is lit only while the ones digit is enabled and the registered `skip_flag` = 1.
- **Polarity:** `COMMON_ANODE`=1 inverts `seg`, `dp` and `an` at the output register.

## Timing
- **Reset values:**
  - FSM: IDLE. Force flag = 1.
  - `bcd` = 0x000, `bcd_valid` = 0.
  - Refresh counter = 0, digit index = 0.
  - `an` enables ones. With CA, `an` = 3'b110.
  - `seg` shows '0'. With CA, `seg` = 7'b1000000.
  - `dp` is off. With CA, `dp` = 1.
- **Reset mid-conversion:** aborts with no `bcd_valid` pulse. The first conversion starts on the first edge after `rst` deasserts.
- **Conversion latency:** let E be the capture edge in IDLE.
  - Edges E+1..E+8 perform the shifts.
  - `bcd` and `bcd_valid` update at E+9.
  - `bcd_valid` falls at E+10.
  - The next capture can occur at E+10. Minimum interval between `bcd_valid` pulses is 10 cycles.
- **Scan timing:**
  - `seg`, `an` and `dp` are registered. They update one cycle after the digit index changes.
  - Each digit is enabled for exactly REFRESH_DIV cycles, and `an` is never all-on or multi-hot.
  - A `bcd` update becomes visible on the current digit within 1 cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with `count_in`=0, `COMMON_ANODE`=1. Expect `an`=110, `seg`=1000000, `dp`=1, `bcd`=0x000, `bcd_valid`=0. After release, expect one `bcd_valid` pulse 10 cycles later with `bcd`=0x000.
- **Full-scale conversion:** `count_in`=255 from idle. Expect `bcd`=0x255 and a single-cycle `bcd_valid` exactly 9 edges after capture. Repeat with 0, 9, 10, 99, 100 → 0x000, 0x009, 0x010, 0x099, 0x100.
- **Scan and blanking:** `REFRESH_DIV`=4, `count_in`=5. Expect the `an` sequence 110, 101, 011, each held 4 cycles. Hundreds and tens show `seg`=1111111. Ones shows `seg`=0010010.
- **Change mid-conversion:** `count_in`=10 at capture E, changed to 99 at E+3. Expect `bcd`=0x010 at E+9, second capture at E+10, `bcd`=0x099 at E+19, and exactly two pulses.
- **Decimal point:** `skip_flag`=1 with `REFRESH_DIV`=4. Expect `dp`=0 only while `an`=110, and `dp`=1 otherwise. With `skip_flag`=0, expect `dp`=1 always.
- **Reset mid-conversion:** assert `rst` at E+4 of a conversion of 200. Expect no `bcd_valid` and `bcd`=0x000. After release, expect `bcd`=0x200 10 cycles later.
